spwm_modulator: RTL and testbench

Sinusoidal PWM modulator for a single-phase full H-bridge. It sits directly downstream of the sine reference generator: it takes the signed, amplitude-scaled reference and compares it against an internal triangular carrier to produce unipolar SPWM. The reference is latched at the carrier peak and valley (double update). The block then drives four complementary gate signals with programmable dead time and a latched fault shutdown.

---
 rtl/spwm_modulator_pkg.sv | 14 +
 rtl/spwm_modulator_deadtime_leg.sv | 76 +++++++
 rtl/spwm_modulator.sv | 130 +++++++++++++
 tb/tb_spwm_modulator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spwm_modulator_pkg.sv
// Shared types for the SPWM modulator.
// Leg FSM encoding and reference offset.
package spwm_modulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L_ON = 2'd1,
    H_ON = 2'd2,
    DEAD = 2'd3
  } leg_state_e;

  localparam int unsigned REF_OFFSET = 32768;

endpackage

// File: rtl/spwm_modulator_deadtime_leg.sv
// One H-bridge leg: complementary gates with dead time.
// Gates are registered from the next-state decode.
module deadtime_leg
  import spwm_modulator_pkg::*;
#(
  parameter int DEADTIME_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      raw_i,
  input  logic [DEADTIME_WIDTH-1:0] deadtime_i,
  input  logic                      run_i,
  input  logic                      kill_i,
  output logic                      hi_o,
  output logic                      lo_o
);

  leg_state_e state_q, state_d;
  logic [DEADTIME_WIDTH-1:0] dcnt_q, dcnt_d;
  logic hi_q, lo_q;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (kill_i || !run_i) begin
      state_d = IDLE;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = DEAD;
          dcnt_d  = deadtime_i;
        end
        L_ON: begin
          if (raw_i) begin
            state_d = DEAD;
            dcnt_d  = deadtime_i;
          end
        end
        H_ON: begin
          if (!raw_i) begin
            state_d = DEAD;
            dcnt_d  = deadtime_i;
          end
        end
        DEAD: begin
          // raw only matters at expiry
          if (dcnt_q == '0) begin
            state_d = raw_i ? H_ON : L_ON;
          end else begin
            dcnt_d = dcnt_q - DEADTIME_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hi_q    <= (state_d == H_ON);
      lo_q    <= (state_d == L_ON);
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/spwm_modulator.sv
// Unipolar SPWM for a full H-bridge: triangle carrier,
// double-update compare, dead-time legs, fault latch.
module spwm_modulator
  import spwm_modulator_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int CARRIER_WIDTH  = 16,
  parameter int DEADTIME_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [DATA_WIDTH-1:0]     sine_in,
  input  logic [CARRIER_WIDTH-1:0]  carrier_period,
  input  logic [DEADTIME_WIDTH-1:0] deadtime,
  input  logic                      fault,
  output logic                      pwm_ah,
  output logic                      pwm_al,
  output logic                      pwm_bh,
  output logic                      pwm_bl,
  output logic                      carrier_sync,
  output logic                      fault_active
);

  localparam int PW = DATA_WIDTH + CARRIER_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MIN_S =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [CARRIER_WIDTH-1:0] cnt_q, cnt_d;
  logic [CARRIER_WIDTH-1:0] cmp_a_q, cmp_a_d;
  logic [CARRIER_WIDTH-1:0] cmp_b_q, cmp_b_d;
  logic up_q, up_d;
  logic run_q;
  logic flt_q, flt_d;
  logic sync_q, sync_d;
  logic run, kill, active, sample;
  logic [DATA_WIDTH-1:0] neg, off_a, off_b;

  assign run    = enable && (carrier_period >= CARRIER_WIDTH'(2));
  assign kill   = !enable || fault || flt_q;
  assign active = run && !kill;

  // saturating negation keeps leg B symmetric at -full-scale
  assign neg   = (sine_in == MIN_S) ? ~MIN_S
               : (~sine_in + DATA_WIDTH'(1));
  assign off_a = sine_in + DATA_WIDTH'(REF_OFFSET);
  assign off_b = neg + DATA_WIDTH'(REF_OFFSET);

  always_comb begin
    cnt_d = cnt_q;
    up_d  = up_q;
    if (!active || !run_q) begin
      cnt_d = '0;
      up_d  = 1'b1;
    end else if (up_q) begin
      if (cnt_q >= carrier_period) begin
        cnt_d = cnt_q - CARRIER_WIDTH'(1);
        up_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + CARRIER_WIDTH'(1);
      end
    end else if (cnt_q == '0) begin
      cnt_d = cnt_q + CARRIER_WIDTH'(1);
      up_d  = 1'b1;
    end else begin
      cnt_d = cnt_q - CARRIER_WIDTH'(1);
    end
  end

  always_comb begin
    sample = active && run_q &&
             (cnt_q == '0 || cnt_q == carrier_period);
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    if (sample) begin
      cmp_a_d = CARRIER_WIDTH'(
        (PW'(off_a) * PW'(carrier_period)) >> DATA_WIDTH);
      cmp_b_d = CARRIER_WIDTH'(
        (PW'(off_b) * PW'(carrier_period)) >> DATA_WIDTH);
    end
    flt_d  = enable && (flt_q || fault);
    sync_d = active && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      up_q    <= 1'b1;
      run_q   <= 1'b0;
      cmp_a_q <= '0;
      cmp_b_q <= '0;
      flt_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      run_q   <= active;
      cmp_a_q <= cmp_a_d;
      cmp_b_q <= cmp_b_d;
      flt_q   <= flt_d;
      sync_q  <= sync_d;
    end
  end

  deadtime_leg #(.DEADTIME_WIDTH(DEADTIME_WIDTH)) u_leg_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_i      (cnt_q < cmp_a_q),
    .deadtime_i (deadtime),
    .run_i      (run),
    .kill_i     (kill),
    .hi_o       (pwm_ah),
    .lo_o       (pwm_al)
  );

  deadtime_leg #(.DEADTIME_WIDTH(DEADTIME_WIDTH)) u_leg_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_i      (cnt_q < cmp_b_q),
    .deadtime_i (deadtime),
    .run_i      (run),
    .kill_i     (kill),
    .hi_o       (pwm_bh),
    .lo_o       (pwm_bl)
  );

  assign carrier_sync = sync_q;
  assign fault_active = flt_q;

endmodule

// File: tb/tb_spwm_modulator.sv
// Self-checking bench for spwm_modulator.
// Random stimulus against a cycle-level behavioural model.
module tb_spwm_modulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] sine_in;
  logic [15:0] carrier_period;
  logic [7:0]  deadtime;
  logic        fault;
  logic        pwm_ah, pwm_al, pwm_bh, pwm_bl;
  logic        carrier_sync, fault_active;

  always #5 clk = ~clk;

  spwm_modulator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .sine_in        (sine_in),
    .carrier_period (carrier_period),
    .deadtime       (deadtime),
    .fault          (fault),
    .pwm_ah         (pwm_ah),
    .pwm_al         (pwm_al),
    .pwm_bh         (pwm_bh),
    .pwm_bl         (pwm_bl),
    .carrier_sync   (carrier_sync),
    .fault_active   (fault_active)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check_eq(string tag, logic [31:0] got,
                          logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: leg output mode and time since carrier start
  localparam int OFF = 0, LOW = 1, HIGH = 2, GAP = 3;
  bit m_started, m_fa, m_sync;
  int m_s, m_cmpa, m_cmpb;
  int m_mode [2];
  int m_rem  [2];

  task automatic model_reset();
    m_started = 0; m_fa = 0; m_sync = 0;
    m_s = 0; m_cmpa = 0; m_cmpb = 0;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = OFF; m_rem[i] = 0;
    end
  endtask

  function automatic int tri_cnt(int s, int p);
    int k;
    k = s % (2 * p);
    return (k <= p) ? k : 2 * p - k;
  endfunction

  function automatic int scale(int v, int p);
    longint t;
    t = (longint'(v) + 64'sd32768) * longint'(p);
    return int'(t >>> 16);
  endfunction

  task automatic model_step();
    int p, sv, dt, cnt, nb;
    bit act;
    bit raw [2];
    p   = int'(carrier_period);
    sv  = int'($signed(sine_in));
    dt  = int'(deadtime);
    act = enable && !fault && !m_fa && p >= 2;
    cnt = m_started ? tri_cnt(m_s, p) : 0;
    raw[0] = cnt < m_cmpa;
    raw[1] = cnt < m_cmpb;
    for (int i = 0; i < 2; i++) begin
      if (!act) begin
        m_mode[i] = OFF; m_rem[i] = 0;
      end else if (m_mode[i] == OFF) begin
        m_mode[i] = GAP; m_rem[i] = dt;
      end else if (m_mode[i] == GAP) begin
        if (m_rem[i] == 0) m_mode[i] = raw[i] ? HIGH : LOW;
        else m_rem[i]--;
      end else if ((m_mode[i] == HIGH) != raw[i]) begin
        m_mode[i] = GAP; m_rem[i] = dt;
      end
    end
    if (act && m_started && (cnt == 0 || cnt == p)) begin
      nb = (sv == -32768) ? 32767 : -sv;
      m_cmpa = scale(sv, p);
      m_cmpb = scale(nb, p);
    end
    m_s = (act && m_started) ? m_s + 1 : 0;
    m_started = act;
    m_sync = act && ((m_started ? tri_cnt(m_s, p) : 0) == 0);
    m_fa = enable && (m_fa || fault);
  endtask

  task automatic tick();
    logic [3:0] exp_g;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    exp_g = {m_mode[0] == HIGH, m_mode[0] == LOW,
             m_mode[1] == HIGH, m_mode[1] == LOW};
    check_eq("gates", {pwm_ah, pwm_al, pwm_bh, pwm_bl}, exp_g);
    check_eq("sync", carrier_sync, m_sync);
    check_eq("fault_active", fault_active, m_fa);
    check_eq("overlap", {pwm_ah & pwm_al, pwm_bh & pwm_bl}, 0);
  endtask

  task automatic restart(int p, int dt, int sv);
    enable = 1'b0;
    tick();
    tick();
    carrier_period = 16'(p);
    deadtime = 8'(dt);
    sine_in = 16'(sv);
    enable = 1'b1;
  endtask

  function automatic int pick_sine();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 32767;
      2: return -32768;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    int last_sync, cnt_h, gap, dt_ref, seg_len;
    bit prev_on, on, gap_open, seen;

    rst_n = 1'b0; enable = 1'b0; fault = 1'b0;
    sine_in = '0; carrier_period = 16'd100; deadtime = '0;
    model_reset();
    #12;
    check_eq("rst_outputs",
      {pwm_ah, pwm_al, pwm_bh, pwm_bl, carrier_sync, fault_active}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // zero reference: sync every 2P cycles
    restart(100, 0, 0);
    last_sync = -1;
    for (int i = 0; i < 450; i++) begin
      tick();
      if (carrier_sync) begin
        if (last_sync >= 0) check_eq("sync_period", cyc - last_sync, 200);
        last_sync = cyc;
      end
    end

    // full scale positive: leg B high never on, low always on
    restart(100, 0, 32767);
    for (int i = 0; i < 200; i++) tick();
    cnt_h = 0;
    seg_len = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cnt_h += pwm_bh;
      seg_len += pwm_bl;
    end
    check_eq("fs_pos_bh", cnt_h, 0);
    check_eq("fs_pos_bl", seg_len, 200);

    // full scale negative: leg A high never on
    restart(100, 0, -32768);
    for (int i = 0; i < 200; i++) tick();
    cnt_h = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cnt_h += pwm_ah;
    end
    check_eq("fs_neg_ah", cnt_h, 0);

    // dead time gaps between gate phases on leg A
    restart(20, 5, 0);
    prev_on = 0; gap_open = 0; gap = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      on = pwm_ah | pwm_al;
      if (prev_on && !on) begin
        gap_open = 1; gap = 1;
      end else if (!on && gap_open) begin
        gap++;
      end else if (on && gap_open) begin
        check_eq("dead_gap", gap, 6);
        gap_open = 0;
      end
      prev_on = on;
    end

    // change reference mid-up-ramp
    restart(100, 0, 0);
    tick();
    for (int i = 0; i < 230; i++) tick();
    sine_in = 16'd16384;
    for (int i = 0; i < 400; i++) tick();

    // fault latch and recovery
    fault = 1'b1;
    tick();
    fault = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("flt_gates", {pwm_ah, pwm_al, pwm_bh, pwm_bl}, 0);
      check_eq("flt_latch", fault_active, 1);
    end
    dt_ref = 3;
    deadtime = 8'(dt_ref);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (carrier_sync) begin
        seen = 1;
        check_eq("recover_latch", fault_active, 0);
      end
    end
    check_eq("recover_sync_seen", seen, 1);
    gap = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      gap++;
      if (pwm_ah | pwm_al | pwm_bh | pwm_bl) seen = 1;
    end
    check_eq("first_gate_delay", seen ? gap : -1, dt_ref + 1);

    // asynchronous reset mid-run
    for (int i = 0; i < 37; i++) tick();
    rst_n = 1'b0;
    #1;
    check_eq("async_rst",
      {pwm_ah, pwm_al, pwm_bh, pwm_bl, carrier_sync, fault_active}, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) tick();

    // P = 1: legs never leave idle
    restart(1, 0, 0);
    cnt_h = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      cnt_h += pwm_ah + pwm_al + pwm_bh + pwm_bl;
    end
    check_eq("small_p_gates", cnt_h, 0);

    // randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      restart(($urandom_range(0, 9) == 0) ? $urandom_range(0, 1)
                                          : $urandom_range(2, 40),
              $urandom_range(0, 6), pick_sine());
      seg_len = $urandom_range(50, 250);
      for (int i = 0; i < seg_len; i++) begin
        if ($urandom_range(0, 19) == 0) sine_in = 16'(pick_sine());
        if ($urandom_range(0, 99) == 0) deadtime = 8'($urandom_range(0, 6));
        fault = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 199) == 0) enable = ~enable;
        tick();
      end
      fault = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
